fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read feeding a 2-entry {pc, instr, brp} queue.
// Latency: a response accepted at edge N is visible as the IF head (if_valid) right after edge N.
// Backpressure: stops requesting (FULL) when both entries are occupied; resumes the cycle after a pop.
// Optional static branch prediction is compiled in with `define FETCH_STATIC_BRP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] pc_if,
    output logic [31:0] instr_if,
    output logic        brp_if
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_FULL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic        push, pop, flush_fifo;

    logic [31:0] pc_q    [2];
    logic [31:0] instr_q [2];

`ifdef FETCH_STATIC_BRP_EN
    logic        pred_taken;
    logic        brp_q [2];
    logic [6:0]  opcode;
    logic [31:0] j_imm, b_imm;

    // Static prediction: JAL and backward conditional branches are taken.
    always_comb begin
        opcode     = imem_rdata[6:0];
        j_imm      = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};
        b_imm      = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                      imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        next_pc    = fetch_pc + 32'd4;
        pred_taken = 1'b0;
        if (opcode == 7'b1101111) begin
            next_pc    = fetch_pc + j_imm;
            pred_taken = 1'b1;
        end else if (opcode == 7'b1100011 && imem_rdata[31]) begin
            next_pc    = fetch_pc + b_imm;
            pred_taken = 1'b1;
        end
    end
`else
    assign next_pc = fetch_pc + 32'd4;
`endif

    // Next-state and handshake decode; redirect overrides every other action.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        pop        = 1'b0;
        flush_fifo = 1'b0;
        if (redirect) begin
            flush_fifo = 1'b1;
            state_nxt  = (state == S_REQ && !imem_resp) ? S_FLUSH : S_REQ;
        end else begin
            pop = if_valid && if_ready;
            case (state)
                S_REQ: begin
                    if (imem_resp) begin
                        push      = 1'b1;
                        state_nxt = ((pop ? count : count + 2'd1) == 2'd2) ? S_FULL : S_REQ;
                    end
                end
                S_FULL: begin
                    if (pop) state_nxt = S_REQ;
                end
                S_FLUSH: begin
                    // The in-flight response belongs to the squashed path.
                    if (imem_resp) state_nxt = S_REQ;
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // State, fetch PC, occupancy and queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_fifo) begin
                fetch_pc <= redirect_pc;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (push) begin
                    fetch_pc <= next_pc;
                    wr_ptr   <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue payload; only meaningful under count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= fetch_pc;
            instr_q[wr_ptr] <= imem_rdata;
`ifdef FETCH_STATIC_BRP_EN
            brp_q[wr_ptr]   <= pred_taken;
`endif
        end
    end

    assign imem_read    = (state != S_FULL);
    assign imem_address = fetch_pc;
    assign if_valid     = (count != 2'd0);
    assign pc_if        = if_valid ? pc_q[rd_ptr]    : 32'd0;
    assign instr_if     = if_valid ? instr_q[rd_ptr] : 32'd0;
`ifdef FETCH_STATIC_BRP_EN
    assign brp_if       = if_valid ? brp_q[rd_ptr]   : 1'b0;
`else
    assign brp_if       = 1'b0;
`endif

endmodule
